// File: rtl/regfile_read_stage.sv
// Decode-stage register file (2^ADDR_W x DATA_W, one write port, two read ports) feeding the ID/EX latch.
// Optional macro REGFILE_BYPASS_EN enables write-through bypass for captured and stall-held operands.
module regfile_read_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [ADDR_W-1:0] rd_addr_a_q,
    output logic [ADDR_W-1:0] rd_addr_b_q,
    output logic              valid_out
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] storage [NUM_REGS];
    logic              wr_commit;

    logic [DATA_W-1:0] data_a_p0;
    logic [DATA_W-1:0] data_b_p0;

    logic [DATA_W-1:0] data_a_p1;
    logic [DATA_W-1:0] data_b_p1;
    logic [ADDR_W-1:0] addr_a_p1;
    logic [ADDR_W-1:0] addr_b_p1;
    logic              vld_p1;

    // Register 0 is never written, so a write to it is simply dropped here.
    assign wr_commit = wr_en && (wr_addr != '0);

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] value;
        if (addr == '0) begin
            value = '0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (wr_commit && (wr_addr == addr)) begin
            value = wr_data;
        end
`endif
        else begin
            value = storage[addr];
        end
        return value;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                storage[i] <= '0;
            end
        end else if (wr_commit) begin
            storage[wr_addr] <= wr_data;
        end
    end

    // ---- p0: combinational operand read ----
    always_comb begin
        data_a_p0 = read_port(rd_addr_a);
        data_b_p0 = read_port(rd_addr_b);
    end

    // ---- p1: ID/EX latch (flush beats stall beats capture) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_a_p1 <= '0;
            data_b_p1 <= '0;
            addr_a_p1 <= '0;
            addr_b_p1 <= '0;
            vld_p1    <= 1'b0;
        end else if (flush) begin
            data_a_p1 <= '0;
            data_b_p1 <= '0;
            addr_a_p1 <= '0;
            addr_b_p1 <= '0;
            vld_p1    <= 1'b0;
        end else if (stall) begin
`ifdef REGFILE_BYPASS_EN
            // A held instruction picks up a writeback to its own sources so it never goes stale.
            if (wr_commit && (wr_addr == addr_a_p1)) begin
                data_a_p1 <= wr_data;
            end
            if (wr_commit && (wr_addr == addr_b_p1)) begin
                data_b_p1 <= wr_data;
            end
`endif
        end else begin
            data_a_p1 <= data_a_p0;
            data_b_p1 <= data_b_p0;
            addr_a_p1 <= rd_addr_a;
            addr_b_p1 <= rd_addr_b;
            vld_p1    <= valid_in;
        end
    end

    assign rd_data_a   = data_a_p1;
    assign rd_data_b   = data_b_p1;
    assign rd_addr_a_q = addr_a_p1;
    assign rd_addr_b_q = addr_b_p1;
    assign valid_out   = vld_p1;

endmodule

// File: doc/regfile_read_stage.md
Name: regfile_read_stage

Overview:
- Register-file read side of the pipelined CPU's decode stage: 2^ADDR_W x DATA_W storage, one write port driven by writeback, two read ports.
- Read results, source addresses and a valid bit are registered into the ID/EX pipeline latch.
- The latch supports stall and flush for hazard and branch control.
- Gives the execute stage operand values plus the source addresses that the forwarding logic needs.

Parameters:
- DATA_W, 32, width of each register and data port.
- ADDR_W, 5, register address width; number of registers = 2^ADDR_W.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset: the block resets while reset=0, independent of clk.
- wr_en  input  1  writeback write enable.
- wr_addr  input  ADDR_W  writeback destination register.
- wr_data  input  DATA_W  writeback data.
- rd_addr_a  input  ADDR_W  source register A of the decoding instruction.
- rd_addr_b  input  ADDR_W  source register B of the decoding instruction.
- valid_in  input  1  decoding instruction is valid.
- stall  input  1  hold the ID/EX latch.
- flush  input  1  squash the ID/EX latch (insert bubble).
- rd_data_a  output  DATA_W  latched operand A.
- rd_data_b  output  DATA_W  latched operand B.
- rd_addr_a_q  output  ADDR_W  latched source address A.
- rd_addr_b_q  output  ADDR_W  latched source address B.
- valid_out  output  1  latched instruction valid.

Behaviour:
- Reset (reset=0, async): all storage registers = 0; rd_data_a/b = 0, rd_addr_a_q/b_q = 0, valid_out = 0.
- Register 0 is hardwired: writes to address 0 are ignored and reads of address 0 always return 0.
- Write: on posedge, if wr_en=1 and wr_addr!=0, storage[wr_addr] <= wr_data. Writes are independent of stall and flush and always commit.
- Latch update priority per posedge, highest first:
  - flush=1: valid_out<=0, rd_data_a/b<=0, rd_addr_a_q/b_q<=0. Flush overrides stall.
  - else stall=1: all latch outputs hold (subject to Optional Feature).
  - else: rd_data_a<=read(rd_addr_a), rd_data_b<=read(rd_addr_b), rd_addr_*_q<=rd_addr_*, valid_out<=valid_in.
- Latency: 1 cycle from address presentation to rd_data_* visible.
- read(x) depends on the Optional Feature. Both ports resolve independently; rd_addr_a==rd_addr_b is legal and both return the same value.
- Latched data is captured regardless of valid_in; only valid_out marks it meaningful.
- Reset asserted mid-operation: all latch and storage contents are lost immediately; the first capture after reset deasserts follows the normal rules.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined, write-through bypass:
  - When wr_en=1, wr_addr!=0 and wr_addr equals the read address in the capture cycle, read() returns wr_data (write-first).
  - During stall (flush=0), a committing write whose wr_addr equals rd_addr_a_q or rd_addr_b_q (nonzero) also refreshes the corresponding held rd_data_* with wr_data. A stalled instruction therefore never holds a stale operand.
- Undefined:
  - read() returns pre-write storage contents (read-first); a same-cycle write is visible only from the following capture.
  - Held outputs stay frozen during stall.

Test Plan:
- Reset: reset=0 for 2 cycles, then 1; read addrs 1 and 31 -> rd_data_a/b=0, valid_out=0 until valid_in captured.
- R0: write 0xDEADBEEF to addr 0, then read addr 0 on both ports -> rd_data_a=rd_data_b=0.
- Write/read: write 0x12345678 to r5 in cycle N; read r5 in cycle N+1 -> rd_data_a=0x12345678 one cycle later, rd_addr_a_q=5, valid_out=1.
- Same-cycle collision: r7=0x11, then write r7=0x22 while reading r7 -> rd_data_a=0x22 with REGFILE_BYPASS_EN, 0x11 without.
- Stall: latch r3 (=0xA), assert stall 3 cycles while writing r3=0xB -> rd_data_a=0xB after the write with REGFILE_BYPASS_EN, stays 0xA without; valid_out held at 1.
- Flush vs stall: assert flush and stall together with valid_in=1 -> valid_out=0 and rd_data_a/b=0 next cycle; a write issued in that same cycle is still committed, and a later read returns the written value.
